fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
Read-side consumer for async_fifo, instantiated in the rclk domain. It issues rden against the FIFO's empty flag and absorbs the FIFO's fixed read latency. It re-presents the data as a valid/ready stream with no bubbles and no loss under downstream backpressure. Internally it is a small skid buffer plus in-flight read tracking.

Parameters:
DWIDTH, 32, data width; must match async_fifo DWIDTH.
RD_LAT, 1, cycles from rden sampled high to dout valid; legal range 1..3.
DEPTH (localparam), RD_LAT+2, skid buffer entries.

Ports:
clk  input  1  clock; connect to the FIFO's rclk.
rstn  input  1  asynchronous active-low reset.
fifo_empty  input  1  async_fifo empty flag.
fifo_rden  output  1  read enable to async_fifo.
fifo_dout  input  DWIDTH  async_fifo read data.
m_valid  output  1  stream data valid.
m_ready  input  1  stream consumer ready.
m_data  output  DWIDTH  stream data; head of skid buffer.
level  output  $clog2(DEPTH+1)  number of words held in the skid buffer.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rstn). During reset: m_valid=0, m_data=0, level=0, fifo_rden=0. All buffer pointers, the in-flight pipe and the run flag are cleared.
- run flag: a register, 0 in reset, set to 1 at the first clk edge after rstn rises. fifo_rden is forced to 0 while run=0, so the first possible rden is in the 2nd cycle after release.
- Issue rule (combinational, registered terms only, no path from m_ready): fifo_rden = run && !fifo_empty && (level + inflight) < DEPTH.
- inflight = number of 1s in an RD_LAT-deep shift register of issued rden bits. Each bit that leaves the pipe writes fifo_dout into the buffer at that edge.
- Latency (RD_LAT=1): rden high in cycle t; data captured at the end of cycle t+1; m_valid high in cycle t+2. In general the first m_valid comes RD_LAT+1 cycles after rden.
- Pop: m_valid && m_ready at a clk edge removes the head entry.
- Push and pop in the same cycle: level is unchanged and both pointers advance.
- Buffer: DEPTH-entry circular buffer with pointers modulo DEPTH (wrap from DEPTH-1 to 0) and a level counter.
  - m_valid = (level != 0).
  - m_data is the registered head entry.
  - m_data is held stable while m_valid && !m_ready.
- Overflow cannot occur: the issue rule reserves a slot for every in-flight read. An assertion checks that no capture happens when level == DEPTH.
- Throughput: with m_ready=1 and the FIFO non-empty, fifo_rden and m_valid are high every cycle in steady state.
- Order: words are output strictly in FIFO read order. No duplication, no drop.
- fifo_empty is never sampled for data validity; only the in-flight pipe decides capture.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO read side must be reset in the same assertion.

Decomposition:
- Package fifo_pkg: default DWIDTH/AWIDTH constants shared with async_fifo and a function clog2_p1(n) for level width.
- Sub-module fifo_rd_skid_buf (DWIDTH, DEPTH): circular buffer with push, pop, head data and level.
- Issue logic, run flag and in-flight pipe stay in fifo_rd_stream.

Test Plan:
1. Reset: hold rstn low 3 cycles with fifo_empty=0 -> fifo_rden=0, m_valid=0, level=0. After release, fifo_rden first goes high in the 2nd cycle.
2. Streaming (RD_LAT=1): FIFO model preloaded with ~1..~8, m_ready=1 -> fifo_rden high 8 consecutive cycles. m_data = ~1..~8 on 8 consecutive cycles, the first 2 cycles after the first rden.
3. Backpressure: same preload, m_ready=0 -> exactly 3 rden pulses, level=3, m_data=~1 held. Raise m_ready after 10 cycles -> ~1..~8 delivered in order, nothing lost.
4. Empty gating: fifo_empty toggles randomly while 50 $random words are fed and m_ready is random -> fifo_rden never high with fifo_empty=1, and all 50 words match in order.
5. Mid-stream reset: rstn pulled low with level=2 and 1 word in flight -> m_valid=0 and level=0 immediately. No stale word appears after release.
6. RD_LAT=2 build (DEPTH=4): repeat scenario 2 -> first m_valid 3 cycles after the first rden. Repeat scenario 3 -> 4 rden pulses and level=4.

Source files
------------

// File: rtl/fifo_pkg.sv
// Constants shared by async_fifo and its read-side consumer, plus a width
// helper for counters that must hold the value n itself.
package fifo_pkg;

    localparam int FIFO_DWIDTH = 32;
    localparam int FIFO_AWIDTH = 4;

    function automatic int clog2_p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Small circular buffer behind the FIFO read port: one push and one pop per
// clock, registered head entry, occupancy counter.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DWIDTH = FIFO_DWIDTH,
    parameter int DEPTH  = 3
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  logic [DWIDTH-1:0]            push_data,
    input  logic                         pop,
    output logic [DWIDTH-1:0]            head_data,
    output logic [clog2_p1(DEPTH)-1:0]   level
);

    localparam int LW = clog2_p1(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              pop_ok;

    assign pop_ok    = pop && (level != '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
        end else if (pop_ok) begin
            rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PW'(1);
        end
    end

    // Simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level <= '0;
        end else begin
            case ({push, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    overflow_chk: assert property (
        @(posedge clk) disable iff (!rstn) !(push && (level == FULL_LVL))
    );

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for async_fifo: issues rden against empty, tracks reads
// in flight through the FIFO latency, and re-presents data as valid/ready.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DWIDTH = FIFO_DWIDTH,
    parameter int RD_LAT = 1
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              fifo_empty,
    output logic                              fifo_rden,
    input  logic [DWIDTH-1:0]                 fifo_dout,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DWIDTH-1:0]                 m_data,
    output logic [clog2_p1(RD_LAT+2)-1:0]     level
);

    localparam int DEPTH = RD_LAT + 2;
    localparam int LW    = clog2_p1(DEPTH);
    localparam logic [LW:0] DEPTH_W = (LW+1)'(DEPTH);

    logic              run_q;
    logic [RD_LAT-1:0] rd_pipe_q;
    logic [LW-1:0]     inflight;
    logic [LW:0]       occupancy;
    logic              push;
    logic              pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Bit i set means a read issued i+1 clocks ago; the MSB marks the cycle
    // in which fifo_dout carries that word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_pipe_q <= '0;
        end else begin
            rd_pipe_q <= RD_LAT'({rd_pipe_q, fifo_rden});
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + LW'(rd_pipe_q[i]);
        end
    end

    // Only registered terms feed the issue decision, so every in-flight read
    // already owns a buffer slot and m_ready never reaches fifo_rden.
    assign occupancy = {1'b0, level} + {1'b0, inflight};
    assign fifo_rden = run_q && !fifo_empty && (occupancy < DEPTH_W);

    assign push    = rd_pipe_q[RD_LAT-1];
    assign m_valid = (level != '0);
    assign pop     = m_valid && m_ready;

    fifo_rd_skid_buf #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_skid_buf (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (fifo_dout),
        .pop       (pop),
        .head_data (m_data),
        .level     (level)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: RD_LAT=1 and RD_LAT=2 builds share one
// FIFO read-side model selected by sel.
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sel = 1'b0;
    logic        m_ready = 1'b0;
    logic        force_empty = 1'b0;
    logic        model_empty = 1'b1;
    logic        fifo_empty;
    logic [31:0] fifo_dout;

    logic        rden1, rden2, mv1, mv2;
    logic [31:0] md1, md2;
    logic [1:0]  lv1;
    logic [2:0]  lv2;

    logic        rden, mv;
    logic [31:0] md;
    logic [2:0]  lv;

    logic [31:0] q[$];
    logic [31:0] exp_q[$];
    logic [31:0] dly [3];

    int n_checks = 0;
    int n_errors = 0;
    int t, n_rden, first_rden, last_rden, first_vld, last_vld, n_got, viol;

    always #5 clk = ~clk;

    assign fifo_empty = model_empty | force_empty;
    assign fifo_dout  = sel ? dly[1] : dly[0];
    assign rden       = sel ? rden2 : rden1;
    assign mv         = sel ? mv2 : mv1;
    assign md         = sel ? md2 : md1;
    assign lv         = sel ? lv2 : {1'b0, lv1};

    fifo_rd_stream #(.DWIDTH(32), .RD_LAT(1)) u_dut_lat1 (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_rden(rden1),
        .fifo_dout(fifo_dout), .m_valid(mv1), .m_ready(m_ready),
        .m_data(md1), .level(lv1)
    );

    fifo_rd_stream #(.DWIDTH(32), .RD_LAT(2)) u_dut_lat2 (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_rden(rden2),
        .fifo_dout(fifo_dout), .m_valid(mv2), .m_ready(m_ready),
        .m_data(md2), .level(lv2)
    );

    // FIFO read port: a word popped on a sampled rden appears on dout RD_LAT
    // clocks later; otherwise dout carries a junk pattern.
    always @(posedge clk) begin
        logic [31:0] w;
        w = 32'hDEAD_BEEF;
        if (rstn && rden && q.size() > 0) begin
            w = q.pop_front();
        end
        dly[0] <= w;
        dly[1] <= dly[0];
        dly[2] <= dly[1];
        model_empty <= (q.size() == 0);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic load_seq(input int n, input logic [31:0] base, input bit invert);
        q.delete();
        exp_q.delete();
        for (int i = 1; i <= n; i++) begin
            logic [31:0] w;
            w = invert ? ~(base + 32'(i)) : base + 32'(i);
            q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rstn = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        check("rst_rden", {31'b0, rden}, 32'd0);
        check("rst_valid", {31'b0, mv}, 32'd0);
        check("rst_level", {29'b0, lv}, 32'd0);
        check("rst_data", md, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        t = 0; n_rden = 0; first_rden = -1; last_rden = -1;
        first_vld = -1; last_vld = -1; n_got = 0; viol = 0;
        #1;
        check("rel_rden", {31'b0, rden}, 32'd0);
    endtask

    // Drive at each falling edge, then sample what the next rising edge sees.
    task automatic run_phase(input int ncyc, input bit rnd, input logic rdy);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (rnd) begin
                m_ready     = 1'($urandom_range(0, 1));
                force_empty = ($urandom_range(0, 2) == 0);
            end else begin
                m_ready     = rdy;
                force_empty = 1'b0;
            end
            #1;
            t++;
            if (rden && fifo_empty) viol++;
            if (rden) begin
                n_rden++;
                if (first_rden < 0) first_rden = t;
                last_rden = t;
            end
            if (mv && m_ready) begin
                n_got++;
                if (first_vld < 0) first_vld = t;
                last_vld = t;
                if (exp_q.size() > 0) check("data", md, exp_q.pop_front());
            end
        end
    endtask

    task automatic stream_test(input int lat);
        load_seq(8, 32'd0, 1'b1);
        m_ready = 1'b1;
        do_reset(3);
        run_phase(20, 1'b0, 1'b1);
        check("st_first_rden", first_rden, 32'd1);
        check("st_rden_run", last_rden - first_rden + 1, 32'd8);
        check("st_rden_cnt", n_rden, 32'd8);
        check("st_latency", first_vld - first_rden, lat + 1);
        check("st_valid_run", last_vld - first_vld + 1, 32'd8);
        check("st_count", n_got, 32'd8);
    endtask

    task automatic bp_test(input int lat);
        load_seq(8, 32'd0, 1'b1);
        m_ready = 1'b0;
        do_reset(3);
        run_phase(12, 1'b0, 1'b0);
        check("bp_rden_cnt", n_rden, lat + 2);
        check("bp_level", {29'b0, lv}, lat + 2);
        check("bp_valid", {31'b0, mv}, 32'd1);
        check("bp_head_held", md, ~32'd1);
        run_phase(40, 1'b0, 1'b1);
        check("bp_count", n_got, 32'd8);
        check("bp_rden_total", n_rden, 32'd8);
        check("bp_drained", {29'b0, lv}, 32'd0);
    endtask

    initial begin
        // RD_LAT=1: reset/startup, streaming, backpressure
        sel = 1'b0;
        stream_test(1);
        bp_test(1);

        // empty gating with random empty and ready
        q.delete();
        exp_q.delete();
        for (int i = 0; i < 50; i++) begin
            logic [31:0] w;
            w = $urandom();
            q.push_back(w);
            exp_q.push_back(w);
        end
        do_reset(2);
        run_phase(1000, 1'b1, 1'b0);
        check("rand_count", n_got, 32'd50);
        check("rand_rden_on_empty", viol, 32'd0);

        // reset with two words buffered and one in flight
        load_seq(8, 32'd0, 1'b1);
        m_ready = 1'b0;
        do_reset(2);
        run_phase(4, 1'b0, 1'b0);
        check("mid_level", {29'b0, lv}, 32'd2);
        check("mid_issued", n_rden, 32'd3);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, mv}, 32'd0);
        check("mid_rst_level", {29'b0, lv}, 32'd0);
        load_seq(4, 32'h5000_0000, 1'b0);
        do_reset(2);
        run_phase(20, 1'b0, 1'b1);
        check("mid_after_count", n_got, 32'd4);

        // RD_LAT=2 build
        sel = 1'b1;
        stream_test(2);
        bp_test(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
